// File: rtl/vce_pkg.sv
// rtl/vce_pkg.sv - shared VCE register offsets, CR fields and CRAM types
package vce_pkg;

  localparam logic [2:0] VCE_CR      = 3'd0;
  localparam logic [2:0] VCE_ADDR_LO = 3'd2;
  localparam logic [2:0] VCE_ADDR_HI = 3'd3;
  localparam logic [2:0] VCE_DATA_LO = 3'd4;
  localparam logic [2:0] VCE_DATA_HI = 3'd5;

  localparam int CR_MODE_LSB = 0;
  localparam int CR_MODE_MSB = 1;
  localparam int CR_BLEND    = 2;
  localparam int CR_GRAY     = 7;

  typedef logic [8:0] cram_addr_t;
  typedef logic [8:0] cram_word_t;

  // CRAM addressing is 9-bit, so the increment wraps 0x1FF -> 0x000
  function automatic cram_addr_t cram_inc(input cram_addr_t a);
    return a + 9'd1;
  endfunction

endpackage

// File: rtl/vce_cram_arbiter_if.sv
// rtl/vce_cram_arbiter_if.sv - CPU register bus and pixel lookup signals of the VCE
interface vce_cram_arbiter_if;
  import vce_pkg::*;

  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic [2:0] A;
  logic [7:0] din;
  logic [7:0] dout;
  logic       pix_en;
  cram_addr_t pix_index;
  cram_word_t pix_color;

  modport master (
    output cs_n, wr_n, rd_n, A, din, pix_en, pix_index,
    input  dout, pix_color
  );

  modport slave (
    input  cs_n, wr_n, rd_n, A, din, pix_en, pix_index,
    output dout, pix_color
  );

endinterface

// File: rtl/vce_cram.sv
// rtl/vce_cram.sv - 512x9 single-port colour RAM, read-first, one-cycle read latency
module vce_cram
  import vce_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  cram_addr_t addr,
  input  cram_word_t wdata,
  output cram_word_t rdata
);

  // no reset on purpose so the array maps onto block RAM
  cram_word_t mem [0:511];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vce_cram_arbiter.sv
// rtl/vce_cram_arbiter.sv - shares the CRAM port between pixel lookups and CPU register traffic
module vce_cram_arbiter
  import vce_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_N,
  vce_cram_arbiter_if.slave    bus,
  output logic [7:0]           cr
);

  logic       acc, acc_q, acc_start, acc_end;
  logic       rd_acc_q;
  logic [2:0] rd_a_q;
  cram_addr_t addr, waddr, ram_addr;
  cram_word_t wdata, rdlatch, ram_wdata, ram_rdata;
  logic [7:0] data_lo;
  logic       wr_pend, pf_pend, pf_inflight, pix_q;
  logic       grant_wr, grant_pf, ram_we;

  assign acc       = !bus.cs_n && (!bus.wr_n || !bus.rd_n);
  assign acc_start = acc && !acc_q;
  assign acc_end   = !acc && acc_q;

  // fixed priority: pixel lookup, then pending write, then prefetch
  always_comb begin
    grant_wr  = 1'b0;
    grant_pf  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr;
    ram_wdata = wdata;
    if (bus.pix_en) begin
      ram_addr = bus.pix_index;
    end else if (wr_pend) begin
      grant_wr = 1'b1;
      ram_we   = 1'b1;
      ram_addr = waddr;
    end else if (pf_pend) begin
      grant_pf = 1'b1;
    end
  end

  always_comb begin
    bus.dout = 8'h00;
    if (reset_N && !bus.cs_n && !bus.rd_n) begin
      case (bus.A)
        VCE_DATA_LO: bus.dout = rdlatch[7:0];
        VCE_DATA_HI: bus.dout = {7'h7F, rdlatch[8]};
        default:     bus.dout = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      acc_q         <= 1'b0;
      rd_acc_q      <= 1'b0;
      rd_a_q        <= 3'd0;
      addr          <= '0;
      waddr         <= '0;
      wdata         <= '0;
      data_lo       <= 8'h00;
      rdlatch       <= '0;
      wr_pend       <= 1'b0;
      pf_pend       <= 1'b0;
      pf_inflight   <= 1'b0;
      pix_q         <= 1'b0;
      cr            <= 8'h00;
      bus.pix_color <= '0;
    end else begin
      acc_q       <= acc;
      pix_q       <= bus.pix_en;
      pf_inflight <= grant_pf;
      if (pix_q)       bus.pix_color <= ram_rdata;
      if (pf_inflight) rdlatch       <= ram_rdata;

      if (grant_wr) begin
        addr    <= cram_inc(waddr);
        wr_pend <= 1'b0;
        pf_pend <= 1'b1;
      end else if (grant_pf) begin
        pf_pend <= 1'b0;
      end

      // CPU updates come last so a fresh request re-arms pf_pend over a clear
      if (acc_start) begin
        rd_acc_q <= bus.wr_n;
        rd_a_q   <= bus.A;
        if (!bus.wr_n) begin
          case (bus.A)
            VCE_CR: cr <= bus.din;
            VCE_ADDR_LO: begin
              addr    <= {addr[8], bus.din};
              pf_pend <= 1'b1;
            end
            VCE_ADDR_HI: begin
              addr    <= {bus.din[0], addr[7:0]};
              pf_pend <= 1'b1;
            end
            VCE_DATA_LO: data_lo <= bus.din;
            VCE_DATA_HI: begin
              wdata   <= {bus.din[0], data_lo};
              waddr   <= addr;
              wr_pend <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (acc_end && rd_acc_q && (rd_a_q == VCE_DATA_HI)) begin
        addr    <= cram_inc(addr);
        pf_pend <= 1'b1;
      end
    end
  end

  vce_cram u_cram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/vce_cram_arbiter.md
# vce_cram_arbiter

Sequencer and arbiter for the VCE's 512×9 colour RAM (CRAM). It shares the single RAM port between the pixel lookup path (palette index from the VDC) and the CPU register interface: control register, colour-table address and colour-table data. It owns address auto-increment, write assembly from byte halves, and read prefetch. The pixel path always wins the port; CPU traffic fills the idle slots.

## Interface
Parameters: none.

Ports:
- clk, input, 1: master clock. This is the same clock that feeds clk_divide.
- reset_N, input, 1: reset. Asynchronous, active-low.
- cs_n, input, 1: CPU chip select, active-low.
- wr_n, input, 1: CPU write strobe, active-low.
- rd_n, input, 1: CPU read strobe, active-low.
- A, input, 3: CPU register select.
- din, input, 8: CPU write data.
- dout, output, 8: CPU read data.
- pix_en, input, 1: pixel lookup request, one cycle per dot.
- pix_index, input, 9: palette index taken from VD.
- pix_color, output, 9: CRAM word, GRB 3:3:3.
- cr, output, 8: control register. cr[1:0] drives the clk_divide mode input.

## Operation
**Register map (A):**
- 0: write CR.
- 2: write addr[7:0].
- 3: write addr[8] = din[0].
- 4: write data_lo, or read rdlatch[7:0].
- 5: write commit, or read {7'h7F, rdlatch[8]}.
- 1, 6, 7: reads return 8'hFF; writes are ignored.

**CPU access detection:**
- An access starts on the first clk edge with cs_n=0 and (wr_n=0 or rd_n=0), following a cycle where that condition was false.
- A and din are sampled on that start edge.

**CPU writes:**
- A=0: CR <= din.
- A=2 or A=3: update addr, then set pf_pend.
- A=4: data_lo <= din. CRAM is not written.
- A=5: wdata <= {din[0], data_lo}, waddr <= addr, then set wr_pend.

**CPU reads:**
- dout is combinational from A and the latches whenever cs_n=0 and rd_n=0. It is 8'h00 otherwise.
- On access end (strobe returns high), if A=5: addr <= addr+1, then set pf_pend.

**Port arbitration** (one RAM operation per cycle, fixed priority):
1. pix_en: read pix_index.
2. wr_pend: write wdata to waddr. Then addr <= waddr+1, clear wr_pend, set pf_pend.
3. pf_pend: read addr. One cycle later rdlatch <= RAM data, and pf_pend clears.

A new pf_pend request that arrives while a prefetch is in flight re-arms the flag. The latest addr always wins.

**Boundary rules:**
- Address arithmetic is 9-bit, so 0x1FF+1 wraps to 0x000.
- A second A=5 write while wr_pend is still set overwrites wdata/waddr (last wins). The CPU timing rule below makes this unreachable.
- CR writes are never deferred.

## Timing
**Pixel lookup:**
- pix_en=1 in cycle N means the RAM is addressed with pix_index in cycle N.
- pix_color holds CRAM[pix_index] from cycle N+2 onward and is otherwise held.
- pix_en is never high in two consecutive cycles. The minimum dot period is 4 clk, in mode 2/3.

**CPU service latency:**
- A pending write commits no later than 2 cycles after its start edge.
- rdlatch is valid no later than 4 cycles after the access that triggered the prefetch.

**CPU bus rule:** consecutive CPU accesses are at least 6 clk apart, start to start, so rdlatch is always valid when read.

**Reset values (reset_N=0, asynchronous):**
- Outputs: cr=0, pix_color=0, dout=0.
- Internal state: addr=0, data_lo=0, rdlatch=0, wr_pend=0, pf_pend=0.
- Reset during a pending write drops the write, and CRAM contents are unchanged.
- CRAM itself is not cleared.

## Structure
**Shared package vce_pkg:**
- Register offsets: VCE_CR=0, VCE_ADDR_LO=2, VCE_ADDR_HI=3, VCE_DATA_LO=4, VCE_DATA_HI=5.
- CR bit positions: mode [1:0], blend [2], gray [7].
- typedef cram_addr_t = logic [8:0].
- typedef cram_word_t = logic [8:0].

**Sub-module vce_cram:**
- 512×9 synchronous single-port RAM with 1-cycle read latency and write-enable.
- The arbiter instantiates it.
- There is no RAM reset, so it maps to block RAM.

## Test plan
1. **Write then read back.**
   - Stimulus: write A2=0x10, A3=0x00, A4=0xA5, A5=0x01; then write A2=0x10, A3=0x00; then read A4 and A5.
   - Required: A4 reads 0xA5, A5 reads 0xFF (bit 0 = 1), and addr ends at 0x011.
2. **Auto-increment and wrap.**
   - Stimulus: set addr=0x1FF, then write two words, 0x155 and 0x0AA.
   - Required: CRAM[0x1FF]=0x155, CRAM[0x000]=0x0AA, addr=0x001.
3. **Pixel priority.**
   - Stimulus: assert pix_en on the same cycle a write commit would occur.
   - Required: pix_color shows the old value at N+2, and the write lands in cycle N+1.
4. **Pixel latency.**
   - Stimulus: preload CRAM[0x0C3]=0x1C7, then pulse pix_en with pix_index=0x0C3 every 4 cycles.
   - Required: pix_color=0x1C7 exactly at N+2.
5. **Control register and unmapped access.**
   - Stimulus: write A0=0x02, then read A7, then write A6.
   - Required: cr=0x02, the A7 read returns 0xFF, and the A6 write leaves no state change.
6. **Reset with a pending write.**
   - Stimulus: drive reset_N low one cycle after an A5 start edge.
   - Required: CRAM is unchanged, all outputs are 0, and addr=0.
